// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage of the 16-bit pipelined processor, directly
//   upstream of ID. Owns the PC and the start/stop control FSM, drives the
//   instruction-memory read port and loads the IF/ID pipeline register.
//   Honours the hazard unit's stall and the EX stage's branch redirect.
//   After a HALT is fetched it lets the pipeline drain before raising stop.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           one-cycle pulse, leaves IDLE
//   stop            high while in HALT
//   im_r_data       IM read data (combinational, same cycle as im_addr)
//   im_addr, im_rd  IM address (= pc) and read enable (= RUN)
//   stall           hold PC and IF/ID
//   branch_taken,
//   branch_target   redirect fetch
//   if_id_instr,
//   if_id_pc1,
//   if_id_valid     IF/ID pipeline register (NOP/invalid = all zero)
module if_fetch_stage #(
  parameter int                   OP_WIDTH     = 4,
  parameter int                   ADDR_WIDTH   = 8,
  parameter int                   DATA_WIDTH   = 16,
  parameter logic [OP_WIDTH-1:0]  HALT_OP      = 4'hF,
  parameter int                   DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  stop,
  input  logic [DATA_WIDTH-1:0] im_r_data,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic                  im_rd,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc1,
  output logic                  if_id_valid
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc1;
  logic [CNT_W-1:0]      drain_cnt;
  logic                  is_halt;

  // pc+1 wraps naturally at the address width
  assign pc1     = pc + ADDR_WIDTH'(1);
  assign im_addr = pc;
  assign is_halt = (im_r_data[DATA_WIDTH-1 -: OP_WIDTH] == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      drain_cnt   <= '0;
      if_id_instr <= '0;
      if_id_pc1   <= '0;
      if_id_valid <= 1'b0;
      stop        <= 1'b0;
      im_rd       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            im_rd <= 1'b1;
          end
        end

        RUN: begin
          if (branch_taken) begin
            // redirect wins over stall: the fetched word is on the wrong path
            pc          <= branch_target;
            if_id_instr <= '0;
            if_id_pc1   <= '0;
            if_id_valid <= 1'b0;
          end else if (!stall) begin
            if_id_instr <= im_r_data;
            if_id_pc1   <= pc1;
            if_id_valid <= 1'b1;
            if (is_halt) begin
              // HALT goes down the pipe; pc parks on it and fetch stops
              drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
              state     <= DRAIN;
              im_rd     <= 1'b0;
            end else begin
              pc <= pc1;
            end
          end
        end

        DRAIN: begin
          if (branch_taken) begin
            // an older branch resolved taken: the HALT was speculative
            pc          <= branch_target;
            if_id_instr <= '0;
            if_id_pc1   <= '0;
            if_id_valid <= 1'b0;
            drain_cnt   <= '0;
            state       <= RUN;
            im_rd       <= 1'b1;
          end else if (!stall) begin
            // HALT has moved on to ID; feed bubbles behind it
            if_id_instr <= '0;
            if_id_pc1   <= '0;
            if_id_valid <= 1'b0;
            if (drain_cnt == '0) begin
              state <= HALT;
              stop  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - CNT_W'(1);
            end
          end
        end

        HALT: begin
          // absorbing; only rst leaves
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by a randomized run,
// all checked every cycle against a cycle-level reference model.
module tb_if_fetch_stage;

  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst, start, stall, branch_taken;
  logic [7:0]  branch_target;
  logic        stop, im_rd, if_id_valid;
  logic [15:0] im_r_data, if_id_instr;
  logic [7:0]  im_addr, if_id_pc1;

  logic [15:0] im [0:255];

  int vectors = 0;
  int miscompares = 0;

  // reference model: mode 0 idle, 1 run, 2 draining, 3 halted
  int          m_mode, m_pc, m_pc1, m_done;
  logic [15:0] m_instr;
  logic        m_valid;

  always #5 clk = ~clk;

  assign im_r_data = im[im_addr];

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .im_r_data(im_r_data), .im_addr(im_addr), .im_rd(im_rd),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_im(input bool_halts);
    for (int i = 0; i < 256; i++) begin
      im[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      if (bool_halts && $urandom_range(0, 15) == 0) im[i][15:12] = 4'hF;
    end
  endtask

  task automatic bubble();
    m_instr = '0; m_pc1 = 0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] w);
    if (rst) begin
      m_mode = 0; m_pc = 0; m_done = 0; bubble();
    end else begin
      case (m_mode)
        0: if (start) m_mode = 1;
        1: begin
          if (branch_taken) begin
            m_pc = int'(branch_target); bubble();
          end else if (!stall) begin
            m_instr = w; m_pc1 = (m_pc + 1) % 256; m_valid = 1'b1;
            if (w[15:12] == 4'hF) begin m_mode = 2; m_done = 0; end
            else m_pc = m_pc1;
          end
        end
        2: begin
          if (branch_taken) begin
            m_pc = int'(branch_target); bubble(); m_mode = 1;
          end else if (!stall) begin
            bubble();
            m_done++;
            if (m_done == DRAIN) m_mode = 3;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".im_addr"}, 32'(im_addr), 32'(m_pc));
    check({tag, ".im_rd"},   32'(im_rd),   32'(m_mode == 1));
    check({tag, ".stop"},    32'(stop),    32'(m_mode == 3));
    check({tag, ".instr"},   32'(if_id_instr), 32'(m_instr));
    check({tag, ".pc1"},     32'(if_id_pc1),   32'(m_pc1));
    check({tag, ".valid"},   32'(if_id_valid), 32'(m_valid));
  endtask

  // one clock: model sees the word at its own pc and the inputs at the edge
  task automatic tick(input string tag);
    logic [15:0] w;
    w = im[m_pc];
    @(posedge clk);
    model_step(w);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    tick("reset");
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick("start"); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    m_mode = 0; m_pc = 0; m_pc1 = 0; m_done = 0; m_instr = '0; m_valid = 1'b0;
    fill_im(1'b0);
    #1;
    do_reset();
    check("rst.all_zero", {16'(if_id_instr), 8'(if_id_pc1), 5'd0, if_id_valid, stop, im_rd}, 32'd0);

    // T1: ADD, SUB, HALT then drain
    im[0] = 16'h1123; im[1] = 16'h2456; im[2] = 16'hF000;
    do_start();
    check("t1.addr0", 32'(im_addr), 32'h0);
    tick("t1.f0"); check("t1.pc1_1", 32'(if_id_pc1), 32'h1);
    tick("t1.f1"); check("t1.pc1_2", 32'(if_id_pc1), 32'h2);
    tick("t1.f2"); check("t1.pc1_3", 32'(if_id_pc1), 32'h3);
    check("t1.halt_latched", 32'(if_id_instr), 32'hF000);
    check("t1.im_rd_off", 32'(im_rd), 32'h0);
    for (int i = 1; i <= DRAIN; i++) begin
      tick("t1.drain");
      check("t1.stop_timing", 32'(stop), 32'(i == DRAIN));
    end
    start = 1'b1; tick("t1.start_in_halt"); start = 1'b0;
    check("t1.stop_sticky", 32'(stop), 32'h1);

    // T2: stall at pc=5
    fill_im(1'b0);
    do_reset();
    do_start();
    repeat (5) tick("t2.run");
    check("t2.at5", 32'(im_addr), 32'h5);
    stall = 1'b1;
    repeat (2) begin
      tick("t2.stall");
      check("t2.hold_addr", 32'(im_addr), 32'h5);
      check("t2.hold_pc1", 32'(if_id_pc1), 32'h5);
    end
    stall = 1'b0;
    tick("t2.resume");
    check("t2.resume_pc1", 32'(if_id_pc1), 32'h6);

    // T3: branch overrides stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
    tick("t3.branch");
    stall = 1'b0; branch_taken = 1'b0;
    check("t3.pc40", 32'(im_addr), 32'h40);
    check("t3.bubble", 32'(if_id_valid), 32'h0);

    // T5: wrap at 8'hFF
    branch_taken = 1'b1; branch_target = 8'hFF;
    tick("t5.branch"); branch_taken = 1'b0;
    tick("t5.fetch_ff");
    check("t5.pc1_wrap", 32'(if_id_pc1), 32'h0);
    check("t5.addr_wrap", 32'(im_addr), 32'h0);

    // T4: speculative HALT squashed in the 2nd drain cycle
    fill_im(1'b0);
    im[7] = 16'hF000;
    do_reset();
    do_start();
    repeat (7) tick("t4.run");
    tick("t4.latch_halt");
    tick("t4.drain1");
    branch_taken = 1'b1; branch_target = 8'h10;
    tick("t4.squash"); branch_taken = 1'b0;
    check("t4.pc10", 32'(im_addr), 32'h10);
    check("t4.im_rd_back", 32'(im_rd), 32'h1);
    repeat (8) begin
      tick("t4.after");
      check("t4.no_stop", 32'(stop), 32'h0);
    end

    // T6: reset while draining, then restart
    fill_im(1'b0);
    im[3] = 16'hF000;
    do_reset();
    do_start();
    repeat (4) tick("t6.run");
    rst = 1'b1; tick("t6.rst"); rst = 1'b0;
    check("t6.cleared", {16'(if_id_instr), 8'(if_id_pc1), 5'd0, if_id_valid, stop, im_rd}, 32'd0);
    check("t6.addr0", 32'(im_addr), 32'h0);
    do_start();
    tick("t6.refetch");
    check("t6.pc1_1", 32'(if_id_pc1), 32'h1);

    // randomized run
    fill_im(1'b1);
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst           = ($urandom_range(0, (m_mode == 3) ? 3 : 79) == 0);
      start         = ($urandom_range(0, 7) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = 8'($urandom);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
